// File: rtl/fifo_umbral.sv
// rtl/fifo_umbral.sv - synchronous FIFO with programmable low/high occupancy thresholds
// Optional first-word fall-through read port enabled by defining FIFO_FWFT_EN.
module fifo_umbral #(
  parameter int DATA_WIDTH   = 6,
  parameter int ADDR_WIDTH   = 3,
  parameter int UMBRALES_L_H = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [UMBRALES_L_H-1:0] umbral_LH,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    valid_out,
  output logic                    empty,
  output logic                    full,
  output logic                    almost_empty,
  output logic                    almost_full,
  output logic [ADDR_WIDTH:0]     fifo_count,
  output logic                    error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int TH_W  = UMBRALES_L_H / 2;
  localparam int CMP_W = (ADDR_WIDTH + 1 > TH_W) ? ADDR_WIDTH + 1 : TH_W;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [TH_W-1:0]       th_low, th_high;
  logic                  rd_acc, wr_acc;

  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_empty = (CMP_W'(count) <= CMP_W'(th_low));
  assign almost_full  = (CMP_W'(count) >= CMP_W'(th_high));
  assign fifo_count   = count;

  // A read frees a slot, so a full FIFO can still take a write in the same cycle.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      error   <= 1'b0;
      th_low  <= TH_W'(1);
      th_high <= TH_W'(DEPTH - 2);
    end else begin
      if (init) {th_high, th_low} <= umbral_LH;
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      if (wr_acc && !rd_acc)      count <= count + 1'b1;
      else if (rd_acc && !wr_acc) count <= count - 1'b1;
      if ((wr_en && !wr_acc) || (rd_en && !rd_acc)) error <= 1'b1;
    end
  end

  // Storage is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (reset && wr_acc) mem[wr_ptr] <= data_in;
  end

`ifdef FIFO_FWFT_EN
  assign data_out  = mem[rd_ptr];
  assign valid_out = !empty;
`else
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= rd_acc;
      if (rd_acc) data_out <= mem[rd_ptr];
    end
  end
`endif

endmodule

// File: tb/tb_fifo_umbral.sv
// tb/tb_fifo_umbral.sv - self-checking bench for fifo_umbral against a queue model
module tb_fifo_umbral;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       init = 1'b0;
  logic [7:0] umbral_LH = 8'h00;
  logic       wr_en = 1'b0;
  logic [5:0] data_in = 6'h00;
  logic       rd_en = 1'b0;
  logic [5:0] data_out;
  logic       valid_out, empty, full, almost_empty, almost_full, error;
  logic [3:0] fifo_count;

  fifo_umbral dut (
    .clk(clk), .reset(reset), .init(init), .umbral_LH(umbral_LH),
    .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(data_out), .valid_out(valid_out), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full),
    .fifo_count(fifo_count), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int q[$];
  int m_low, m_high, m_dout;
  bit m_err, m_valid;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an occupancy queue; pop before push so a full FIFO returns its oldest word.
  always @(posedge clk) begin
    if (!reset) begin
      q.delete();
      m_low = 1; m_high = 6; m_err = 1'b0; m_valid = 1'b0; m_dout = 0;
    end else begin
      bit do_rd, do_wr;
      do_rd = rd_en && (q.size() > 0);
      do_wr = wr_en && (q.size() < 8 || do_rd);
      if ((wr_en && !do_wr) || (rd_en && !do_rd)) m_err = 1'b1;
      m_valid = do_rd;
      if (do_rd) m_dout = q.pop_front();
      if (do_wr) q.push_back(int'(data_in));
      if (init) begin
        m_high = int'(umbral_LH[7:4]);
        m_low  = int'(umbral_LH[3:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("fifo_count",   int'(fifo_count),   q.size());
      cmp("empty",        int'(empty),        int'(q.size() == 0));
      cmp("full",         int'(full),         int'(q.size() == 8));
      cmp("almost_empty", int'(almost_empty), int'(q.size() <= m_low));
      cmp("almost_full",  int'(almost_full),  int'(q.size() >= m_high));
      cmp("valid_out",    int'(valid_out),    int'(m_valid));
      cmp("data_out",     int'(data_out),     m_dout);
      cmp("error",        int'(error),        int'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; init = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic fill8();
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; data_in = 6'(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  initial begin
    // Reset then idle
    reset = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    cmp("rst_empty", int'(empty), 1);
    cmp("rst_almost_empty", int'(almost_empty), 1);
    cmp("rst_full", int'(full), 0);
    cmp("rst_almost_full", int'(almost_full), 0);
    cmp("rst_count", int'(fifo_count), 0);
    cmp("rst_valid", int'(valid_out), 0);
    cmp("rst_error", int'(error), 0);
    reset = 1'b1;

    // Thresholds high=5 low=2, then fill
    init = 1'b1; umbral_LH = 8'h52;
    tick();
    init = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; data_in = 6'(i);
      tick();
      cmp("fill_count", int'(fifo_count), i);
      cmp("fill_almost_empty", int'(almost_empty), int'(i <= 2));
      cmp("fill_almost_full", int'(almost_full), int'(i >= 5));
      cmp("fill_full", int'(full), int'(i == 8));
    end
    wr_en = 1'b0;
    cmp("fill_error", int'(error), 0);

    // Drain order
    for (int i = 1; i <= 8; i++) begin
      rd_en = 1'b1;
      tick();
      cmp("drain_valid", int'(valid_out), 1);
      cmp("drain_data", int'(data_out), i);
    end
    rd_en = 1'b0;
    tick();
    cmp("drain_valid_idle", int'(valid_out), 0);
    cmp("drain_empty", int'(empty), 1);
    cmp("drain_error", int'(error), 0);

    // Simultaneous read/write while full
    fill8();
    rd_en = 1'b1; wr_en = 1'b1; data_in = 6'h2A;
    tick();
    wr_en = 1'b0;
    cmp("fullrw_data", int'(data_out), 1);
    cmp("fullrw_count", int'(fifo_count), 8);
    for (int i = 2; i <= 9; i++) begin
      tick();
      cmp("wrap_data", int'(data_out), (i == 9) ? 'h2A : i);
    end
    rd_en = 1'b0;
    tick();
    cmp("wrap_empty", int'(empty), 1);
    cmp("wrap_error", int'(error), 0);

    // Overflow
    fill8();
    wr_en = 1'b1; data_in = 6'h3F;
    tick();
    wr_en = 1'b0;
    cmp("ovf_count", int'(fifo_count), 8);
    cmp("ovf_error", int'(error), 1);

    // Underflow
    do_reset();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    cmp("udf_valid", int'(valid_out), 0);
    cmp("udf_error", int'(error), 1);

    // Reset mid-operation with a pending read
    do_reset();
    init = 1'b1; umbral_LH = 8'h52;
    tick();
    init = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      wr_en = 1'b1; data_in = 6'(i + 10);
      tick();
    end
    wr_en = 1'b0; rd_en = 1'b1; reset = 1'b0;
    tick();
    rd_en = 1'b0; reset = 1'b1;
    cmp("midrst_count", int'(fifo_count), 0);
    cmp("midrst_valid", int'(valid_out), 0);
    for (int i = 1; i <= 6; i++) begin
      wr_en = 1'b1; data_in = 6'(i);
      tick();
      if (i <= 2) cmp("midrst_low_th", int'(almost_empty), int'(i <= 1));
      if (i >= 5) cmp("midrst_high_th", int'(almost_full), int'(i >= 6));
    end
    wr_en = 1'b0;

    // Randomized traffic, including odd thresholds and occasional resets
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 199) != 0);
      init      = ($urandom_range(0, 49) == 0);
      umbral_LH = 8'($urandom);
      wr_en     = ($urandom_range(0, 99) < 55);
      rd_en     = ($urandom_range(0, 99) < 50);
      data_in   = 6'($urandom);
      tick();
    end
    reset = 1'b1; init = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    tick();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
